// File: rtl/df_fir_sequencer.sv
// Time-multiplexed FIR tap engine: one tap per cycle through an external
// combinational coefficient multiplier, accumulated and saturated to 8 bits.
module df_fir_sequencer #(
  parameter int TAPS  = 4,
  parameter int ACC_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [3*TAPS-1:0] coefs,
  output logic [7:0]        mul_data,
  output logic [2:0]        mul_coef,
  input  logic [7:0]        mul_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a sample, in_ready high
  // MAC   | one tap per cycle, idx 0..TAPS-1
  // OUT   | result presented until out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       x_q [TAPS];
  logic [7:0]       x_d [TAPS];
  logic [2:0]       coef_q [TAPS];
  logic [2:0]       coef_d [TAPS];
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;

  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       acc_sat;

  assign acc_sum = acc_q + {{(ACC_W-8){1'b0}}, mul_prod};
  assign acc_sat = (acc_sum > ACC_W'(255)) ? 8'hFF : acc_sum[7:0];

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MAC) || (state_q == OUT);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mul_data  = (state_q == MAC) ? x_q[idx_q]    : 8'd0;
  assign mul_coef  = (state_q == MAC) ? coef_q[idx_q] : 3'd0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    x_d         = x_q;
    coef_d      = coef_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0] = in_data;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          for (int k = 0; k < TAPS; k++) coef_d[k] = coefs[3*k +: 3];
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = acc_sat;
          state_d     = OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        // out_data keeps its value after acceptance
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= 8'd0;
        coef_q[k] <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= x_d[k];
        coef_q[k] <= coef_d[k];
      end
    end
  end

endmodule

// File: tb/tb_df_fir_sequencer.sv
// Directed bench for df_fir_sequencer with a behavioural model of the
// coefficient multiplier driving mul_prod.
module tb_df_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [11:0] coefs;
  logic [7:0]  mul_data;
  logic [2:0]  mul_coef;
  logic [7:0]  mul_prod;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mul_model(input logic [7:0] d, input logic [2:0] c);
    int m;
    m = 5 + 2 * int'(c[0]) + 8 * int'(c[1]) + 32 * int'(c[2]);
    return 8'((int'(d) * m) / 128);
  endfunction

  assign mul_prod = mul_model(mul_data, mul_coef);

  df_fir_sequencer #(.TAPS(4), .ACC_W(11)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coefs(coefs),
    .mul_data(mul_data), .mul_coef(mul_coef), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: out_valid timeout, got 0 expected 1", name);
    end
  endtask

  // Coefs are scrambled right after acceptance to confirm they were latched.
  task automatic push(input logic [7:0] s, input logic [11:0] c, input string name,
                      output logic [7:0] r);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_data = s; coefs = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; coefs = ~c;
    wait_out(name);
    r = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic push_check(input logic [7:0] s, input logic [11:0] c,
                            input logic [7:0] exp, input string name);
    logic [7:0] r;
    push(s, c, name, r);
    checks++;
    if (r !== exp) begin
      errors++;
      $display("FAIL %s: out_data got %0d expected %0d", name, r, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mul_data !== 8'd0) begin errors++; $display("FAIL reset_mul_data: got %0d expected 0", mul_data); end
    checks++; if (mul_coef !== 3'd0) begin errors++; $display("FAIL reset_mul_coef: got %0d expected 0", mul_coef); end
    for (int i = 0; i < 4; i++) push_check(8'd0, 12'hFFF, 8'd0, "reset_zero_push");
  endtask

  task automatic test_impulse();
    logic [7:0] exp_d [4] = '{8'd255, 8'd0, 8'd0, 8'd0};
    logic [7:0] exp_o [4] = '{8'd93, 8'd93, 8'd93, 8'd0};
    in_data = 8'd255; coefs = 12'hFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; coefs = 12'h000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mul_data !== exp_d[i] || mul_coef !== 3'd7) begin
        errors++;
        $display("FAIL impulse_mac%0d: mul_data/coef got %0d/%0d expected %0d/7",
                 i, mul_data, mul_coef, exp_d[i]);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL impulse_busy%0d: busy/in_ready got %b/%b expected 1/0", i, busy, in_ready);
      end
      @(negedge clk);
    end
    wait_out("impulse_first");
    checks++;
    if (out_data !== 8'd93) begin
      errors++; $display("FAIL impulse_first: out_data got %0d expected 93", out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_check(8'd0, 12'hFFF, exp_o[i], "impulse_tail");
  endtask

  task automatic test_saturation();
    logic [7:0] exp_o [4] = '{8'd93, 8'd186, 8'd255, 8'd255};
    for (int i = 0; i < 4; i++) push_check(8'd255, 12'hFFF, exp_o[i], "saturation");
  endtask

  task automatic test_mixed_coef();
    // taps {3,2,1,0} = {0,1,2,4}; delay line starts full of 255
    logic [7:0] exp_o [4] = '{8'd84, 8'd72, 8'd66, 8'd62};
    for (int i = 0; i < 4; i++) push_check(8'd128, 12'h054, exp_o[i], "mixed_coef");
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data = 8'd255; coefs = 12'hFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("bp_wait");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; in_data = 8'hAA;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd93) begin
        errors++;
        $display("FAIL bp_hold%0d: valid/data got %b/%0d expected 1/93", i, out_valid, out_data);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready%0d: in_ready/busy got %b/%b expected 0/1", i, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd93) begin
      errors++;
      $display("FAIL bp_release: valid/data got %b/%0d expected 0/93", out_valid, out_data);
    end
    push_check(8'd0, 12'hFFF, 8'd93, "bp_no_aa_1");
    push_check(8'd0, 12'hFFF, 8'd93, "bp_no_aa_2");
  endtask

  task automatic test_reset_mid_mac();
    in_data = 8'd128; coefs = 12'hFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mul_data !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midmac_idx2: mul_data/busy got %0d/%b expected 0/1", mul_data, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mul_data !== 8'd0) begin
      errors++;
      $display("FAIL midmac_idle: ready/busy/valid/mul_data got %b/%b/%b/%0d expected 1/0/0/0",
               in_ready, busy, out_valid, mul_data);
    end
    push_check(8'd255, 12'hFFF, 8'd93, "midmac_after_1");
    push_check(8'd0, 12'hFFF, 8'd93, "midmac_after_2");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; coefs = 12'd0; out_ready = 1'b0;
    test_reset();
    test_impulse();
    test_saturation();
    test_mixed_coef();
    test_backpressure();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
